// File: rtl/ternary_conv_sched_if.sv
// ternary_conv_sched_if: start/config, accumulator and select-array handshake, buffer read bus
interface ternary_conv_sched_if #(
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic                  cfg_kn_size_mode;
  logic [CNT_WIDTH-1:0]  cfg_in_tiles;
  logic [CNT_WIDTH-1:0]  cfg_out_pixels;
  logic [CNT_WIDTH-1:0]  cfg_out_maps;
  logic                  acc_ready;
  logic                  sel_com_done;
  logic                  feat_rd_en;
  logic [ADDR_WIDTH-1:0] feat_rd_addr;
  logic                  wgt_rd_en;
  logic [ADDR_WIDTH-1:0] wgt_rd_addr;
  logic                  sel_enable;
  logic                  sel_kn_size_mode;
  logic                  acc_first;
  logic                  acc_last;
  logic                  busy;
  logic                  done;
  logic                  err;
  modport master (
    output start, cfg_kn_size_mode, cfg_in_tiles, cfg_out_pixels, cfg_out_maps, acc_ready, sel_com_done,
    input  feat_rd_en, feat_rd_addr, wgt_rd_en, wgt_rd_addr, sel_enable, sel_kn_size_mode,
           acc_first, acc_last, busy, done, err
  );
  modport slave (
    input  start, cfg_kn_size_mode, cfg_in_tiles, cfg_out_pixels, cfg_out_maps, acc_ready, sel_com_done,
    output feat_rd_en, feat_rd_addr, wgt_rd_en, wgt_rd_addr, sel_enable, sel_kn_size_mode,
           acc_first, acc_last, busy, done, err
  );
endinterface

// File: rtl/ternary_conv_sched.sv
// ternary_conv_sched: sequences one ternary conv layer (maps x pixels x Tn tiles) through the select array
//   clk, rst (synchronous, active-low)
//   bus in : start, cfg_kn_size_mode, cfg_in_tiles, cfg_out_pixels, cfg_out_maps, acc_ready, sel_com_done
//   bus out: feat/wgt read strobe + address, sel_enable, sel_kn_size_mode, acc_first/last, busy, done, err
module ternary_conv_sched #(
  parameter logic KERNEL_SIZE_5_MODE = 1'b1,
  parameter logic KERNEL_SIZE_3_MODE = 1'b0,
  parameter int   CNT_WIDTH          = 16,
  parameter int   ADDR_WIDTH         = 16
) (
  input logic clk,
  input logic rst,
  ternary_conv_sched_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;
  localparam logic [CNT_WIDTH-1:0]  cnt_one  = 1;
  localparam logic [ADDR_WIDTH-1:0] addr_one = 1;
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0]  tiles_q, tiles_d, pixels_q, pixels_d, maps_q, maps_d;
  logic [CNT_WIDTH-1:0]  t_q, t_d, p_q, p_d, m_q, m_d;
  logic [ADDR_WIDTH-1:0] feat_q, feat_d, wgt_q, wgt_d, wbase_q, wbase_d;
  logic [1:0]            in_flight_q, in_flight_d;
  logic sel_mode_q, sel_mode_d, sel_en_q, sel_en_d, err_q, err_d;
  logic first1_q, first1_d, last1_q, last1_d, first2_q, first2_d, last2_q, last2_d;
  logic accept, issue, t_last, p_last, m_last, pix_wrap, retire;
  always_comb begin
    accept = (state_q == IDLE) & bus.start;
    issue = (state_q == ISSUE) & bus.acc_ready;
    t_last = t_q == tiles_q - cnt_one;
    p_last = p_q == pixels_q - cnt_one;
    m_last = m_q == maps_q - cnt_one;
    pix_wrap = t_last & p_last;
    retire = bus.sel_com_done & (in_flight_q != 2'd0);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? LOAD : IDLE;
      LOAD:    state_d = (tiles_q == '0 || pixels_q == '0 || maps_q == '0) ? DONE : ISSUE;
      ISSUE:   state_d = (issue & pix_wrap & m_last) ? DRAIN : ISSUE;
      DRAIN:   state_d = (in_flight_q == 2'd0) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
    tiles_d = accept ? bus.cfg_in_tiles : tiles_q;
    pixels_d = accept ? bus.cfg_out_pixels : pixels_q;
    maps_d = accept ? bus.cfg_out_maps : maps_q;
    sel_mode_d = accept ? (bus.cfg_kn_size_mode ? KERNEL_SIZE_5_MODE : KERNEL_SIZE_3_MODE) : sel_mode_q;
    t_d = t_q;
    p_d = p_q;
    m_d = m_q;
    feat_d = feat_q;
    wgt_d = wgt_q;
    wbase_d = wbase_q;
    if (state_q == LOAD) begin
      t_d = '0;
      p_d = '0;
      m_d = '0;
      feat_d = '0;
      wgt_d = '0;
      wbase_d = '0;
    end else if (issue) begin
      // feature address just counts through the map's pixels; weight address rewinds to the map base per pixel
      t_d = t_last ? '0 : t_q + cnt_one;
      p_d = t_last ? (p_last ? '0 : p_q + cnt_one) : p_q;
      m_d = pix_wrap ? m_q + cnt_one : m_q;
      feat_d = pix_wrap ? '0 : feat_q + addr_one;
      wbase_d = pix_wrap ? wbase_q + ADDR_WIDTH'(tiles_q) : wbase_q;
      wgt_d = t_last ? wbase_d : wgt_q + addr_one;
    end
    sel_en_d = issue;
    first1_d = issue & (t_q == '0);
    last1_d = issue & t_last;
    first2_d = first1_q;
    last2_d = last1_q;
    in_flight_d = in_flight_q + {1'b0, issue} - {1'b0, retire};
    err_d = (err_q & ~accept) | (bus.sel_com_done & (in_flight_q == 2'd0));
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tiles_q <= '0;
      pixels_q <= '0;
      maps_q <= '0;
      t_q <= '0;
      p_q <= '0;
      m_q <= '0;
      feat_q <= '0;
      wgt_q <= '0;
      wbase_q <= '0;
      in_flight_q <= '0;
      sel_mode_q <= KERNEL_SIZE_3_MODE;
      sel_en_q <= 1'b0;
      first1_q <= 1'b0;
      last1_q <= 1'b0;
      first2_q <= 1'b0;
      last2_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tiles_q <= tiles_d;
      pixels_q <= pixels_d;
      maps_q <= maps_d;
      t_q <= t_d;
      p_q <= p_d;
      m_q <= m_d;
      feat_q <= feat_d;
      wgt_q <= wgt_d;
      wbase_q <= wbase_d;
      in_flight_q <= in_flight_d;
      sel_mode_q <= sel_mode_d;
      sel_en_q <= sel_en_d;
      first1_q <= first1_d;
      last1_q <= last1_d;
      first2_q <= first2_d;
      last2_q <= last2_d;
      err_q <= err_d;
    end
  end
  assign bus.feat_rd_en = issue;
  assign bus.wgt_rd_en = issue;
  assign bus.feat_rd_addr = feat_q;
  assign bus.wgt_rd_addr = wgt_q;
  assign bus.sel_enable = sel_en_q;
  assign bus.sel_kn_size_mode = sel_mode_q;
  assign bus.acc_first = first2_q;
  assign bus.acc_last = last2_q;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.err = err_q;
endmodule

// File: doc/ternary_conv_sched.md
Name: ternary_conv_sched

Overview:
- Sequences one ternary convolution layer through the Tn-wide ternary select array.
- Walks output-map groups, output pixels and Tn input-channel tiles.
- For each step it issues feature- and weight-buffer reads, then drives the select array enable and kernel-size mode.
- Tags each result with first/last-tile markers for the downstream accumulator, tracks in-flight operations and reports layer completion.

Parameters:
KERNEL_SIZE_5_MODE, 1, kn_size_mode encoding for 5x5 kernels
KERNEL_SIZE_3_MODE, 0, kn_size_mode encoding for 3x3 (paired) kernels
CNT_WIDTH, 16, width of configuration counts
ADDR_WIDTH, 16, width of feature/weight buffer addresses

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
start  in  1  layer start request, sampled in IDLE only
cfg_kn_size_mode  in  1  kernel mode, latched at start
cfg_in_tiles  in  CNT_WIDTH  number of Tn input-channel tiles per output pixel
cfg_out_pixels  in  CNT_WIDTH  output pixels per output map
cfg_out_maps  in  CNT_WIDTH  output maps (one weight set each)
acc_ready  in  1  accumulator can accept issue; must already reserve room for 2 in-flight results
sel_com_done  in  1  ternary_com_done from select array
feat_rd_en  out  1  feature buffer read strobe
feat_rd_addr  out  ADDR_WIDTH  feature buffer word address (one Tn*K*K window per word)
wgt_rd_en  out  1  weight buffer read strobe
wgt_rd_addr  out  ADDR_WIDTH  weight buffer word address
sel_enable  out  1  select array enable
sel_kn_size_mode  out  1  select array kn_size_mode
acc_first  out  1  result arriving with sel_com_done is input tile 0 (clear accumulator)
acc_last  out  1  result arriving with sel_com_done is the last input tile (pixel complete)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky protocol error

Behaviour:
- Reset (rst=0 at an edge): state IDLE; all counters and addresses cleared; in_flight=0. Every output goes to 0; sel_kn_size_mode goes to KERNEL_SIZE_3_MODE. Reset mid-layer aborts immediately, and results still in the select array are ignored.
- States: IDLE, LOAD, ISSUE, DRAIN, DONE.
  - IDLE: start=1 latches all cfg_* values and goes to LOAD. start is ignored in every other state.
  - LOAD: if any latched count is 0, go to DONE; no reads are issued. Otherwise clear the counters and go to ISSUE. sel_kn_size_mode takes the latched mode and holds it until the next start.
- ISSUE, read strobes: feat_rd_en = wgt_rd_en = (state==ISSUE) & acc_ready, combinational. This is an issue. When acc_ready=0 nothing is issued and no counter moves.
- Loop order (outer to inner): out_map m, pixel p, tile t. Each issue advances t. At wrap, t returns to 0 and p advances. At p wrap, p returns to 0 and m advances.
- Addresses: feat_rd_addr = p*in_tiles + t; wgt_rd_addr = m*in_tiles + t. Both are generated by incrementers, not multipliers, and are truncated modulo 2^ADDR_WIDTH.
- The issue with m, p and t all at their maxima is the last issue; the next state is DRAIN.
- Pipeline:
  - sel_enable is the issue strobe registered once (buffer read latency is 1).
  - acc_first (t==0) and acc_last (t==in_tiles-1) are delayed two cycles so they align with sel_com_done.
  - When in_tiles=1, both flags are high.
- in_flight is 2 bits: +1 per issue, -1 per sel_com_done, net 0 when both happen in the same cycle. sel_com_done with in_flight==0 sets err, and in_flight stays 0.
- DRAIN: move to DONE on the first cycle in which in_flight==0.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. err clears only on reset or a new accepted start.
- Latency, with acc_ready held high and N = maps*pixels*tiles. Edge 0 is the edge that samples start; cycle k follows edge k.
  - LOAD in cycle 1; issues in cycles 2..N+1.
  - sel_enable in cycles 3..N+2; sel_com_done in cycles 4..N+3.
  - DRAIN sees in_flight 0 in cycle N+4; done is high in cycle N+5.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles, then release with start=0 -> all outputs 0, busy=0, no read strobes for 20 cycles.
- Small 5x5 layer (in_tiles=2, pixels=3, maps=2, mode=5x5, acc_ready=1, bench models the 1-cycle array):
  - 12 issues in cycles 2..13.
  - feat_rd_addr sequence 0..5 twice; wgt_rd_addr 0,1 repeated three times, then 2,3 three times.
  - acc_first/acc_last alternate, and done is high in cycle 17.
- Single tile, 3x3 mode (in_tiles=1, pixels=4, maps=1) -> sel_kn_size_mode=0 while busy; acc_first=acc_last=1 on all 4 results; done in cycle 9.
- Back-pressure: drop acc_ready for cycles 4..6 in the small layer -> no strobes and no address movement in those cycles; address sequence unchanged; done in cycle 20. A start pulse in cycle 5 is ignored.
- Zero config: pixels=0 -> no rd_en ever; done pulses in cycle 2; busy high in cycles 1..2 only.
- Fault and abort:
  - An extra sel_com_done in IDLE sets err, which clears on the next start.
  - rst=0 in cycle 6 mid-layer returns to IDLE with outputs 0.
  - A late sel_com_done after reset sets err.
